// File: rtl/apb_alu_pkg.sv
// Shared types and constants for the APB ALU sequencer.
// Holds register map, step/state enums and the ALU command set.
package apb_alu_pkg;

    localparam logic [4:0] ADDR_A      = 5'd0;
    localparam logic [4:0] ADDR_B      = 5'd4;
    localparam logic [4:0] ADDR_RESULT = 5'd8;
    localparam logic [4:0] ADDR_CMD    = 5'd12;
    localparam logic [4:0] ADDR_EN     = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_SETTLE,
        ST_FINISH
    } state_e;

    typedef enum logic [2:0] {
        STEP_WA,
        STEP_WB,
        STEP_WCMD,
        STEP_WEN1,
        STEP_RRES,
        STEP_WEN0
    } step_e;

    typedef enum logic [3:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_MUL  = 4'd2,
        CMD_AND  = 4'd3,
        CMD_OR   = 4'd4,
        CMD_XOR  = 4'd5,
        CMD_NOT  = 4'd6,
        CMD_NAND = 4'd7,
        CMD_NOR  = 4'd8,
        CMD_XNOR = 4'd9,
        CMD_SLT  = 4'd10,
        CMD_SLTU = 4'd11,
        CMD_EQ   = 4'd12,
        CMD_SHL  = 4'd13,
        CMD_SHR  = 4'd14,
        CMD_ASHR = 4'd15
    } alu_cmd_e;

    typedef struct packed {
        logic [4:0] addr;
        logic       write;
    } xfer_t;

    // Address and direction of the APB transfer for each step.
    function automatic xfer_t step_xfer(input step_e s);
        xfer_t x;
        x.addr  = ADDR_A;
        x.write = 1'b1;
        case (s)
            STEP_WA:   x.addr = ADDR_A;
            STEP_WB:   x.addr = ADDR_B;
            STEP_WCMD: x.addr = ADDR_CMD;
            STEP_WEN1: x.addr = ADDR_EN;
            STEP_RRES: begin
                x.addr  = ADDR_RESULT;
                x.write = 1'b0;
            end
            STEP_WEN0: x.addr = ADDR_EN;
            default:   x.addr = ADDR_A;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/apb_alu_sequencer_rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// Priority starts just after the last index that was advanced on.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;
    logic [W-1:0] win;
    logic [N-1:0] mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] pick;

    // Lowest requester at or above the pointer wins, else wrap around.
    always_comb begin
        mask   = ~((N'(1) << ptr_q) - N'(1));
        hi_req = req & mask;
        pick   = (|hi_req) ? hi_req : req;
        grant  = pick & (~pick + N'(1));
    end

    // Index of the winner and the pointer that follows it.
    always_comb begin
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win = W'(i);
            end
        end
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (win == W'(N - 1)) ? '0 : win + W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_alu_sequencer.sv
// APB master sharing the memory-mapped ALU between requesters.
// Each request becomes a fixed program/enable/read/disable sequence.
module apb_alu_sequencer
    import apb_alu_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [32*N_REQ-1:0]      req_a,
    input  logic [32*N_REQ-1:0]      req_b,
    input  logic [4*N_REQ-1:0]       req_cmd,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_result,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [4:0]               paddr,
    output logic [31:0]              pwdata,
    input  logic [31:0]              prdata,
    input  logic                     pready
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] ST_LAST = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [IW-1:0] id_q, id_d;
    logic [31:0] res_q, res_d;
    logic        err_q, err_d;

    logic [N_REQ-1:0] grant;
    logic             accept;
    logic [31:0]      a_sel;
    logic [31:0]      b_sel;
    logic [3:0]       cmd_sel;
    logic [IW-1:0]    id_sel;
    xfer_t            xf;
    logic [31:0]      wdata;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .clk    (pclk),
        .rst    (preset),
        .req    (req_valid),
        .advance(accept),
        .grant  (grant)
    );

    // Grant is only offered while idle.
    always_comb begin
        req_ready = (state_q == ST_IDLE) ? grant : '0;
        accept    = |req_ready;
    end

    // Select the granted requester's operands.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cmd_sel = '0;
        id_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                a_sel   = req_a[i*32 +: 32];
                b_sel   = req_b[i*32 +: 32];
                cmd_sel = req_cmd[i*4 +: 4];
                id_sel  = IW'(i);
            end
        end
    end

    // Sequence FSM: next state, step and captured data.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cmd_d   = cmd_q;
        id_d    = id_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    cmd_d   = cmd_sel;
                    id_d    = id_sel;
                    err_d   = 1'b0;
                    step_d  = STEP_WA;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    cnt_d = '0;
                    case (step_q)
                        STEP_WEN1: state_d = ST_SETTLE;
                        STEP_RRES: begin
                            res_d   = prdata;
                            step_d  = STEP_WEN0;
                            state_d = ST_SETUP;
                        end
                        STEP_WEN0: state_d = ST_FINISH;
                        default: begin
                            step_d  = step_e'(step_q + 3'd1);
                            state_d = ST_SETUP;
                        end
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    // Slave stuck: abandon the rest of the sequence.
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == ST_LAST) begin
                    cnt_d   = '0;
                    step_d  = STEP_RRES;
                    state_d = ST_SETUP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // APB drive and response outputs decoded from the registers.
    always_comb begin
        xf = step_xfer(step_q);
        wdata = '0;
        case (step_q)
            STEP_WA:   wdata = a_q;
            STEP_WB:   wdata = b_q;
            STEP_WCMD: wdata = {28'b0, cmd_q};
            STEP_WEN1: wdata = 32'd1;
            default:   wdata = '0;
        endcase
        psel       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        penable    = (state_q == ST_ACCESS);
        paddr      = psel ? xf.addr : '0;
        pwrite     = psel & xf.write;
        pwdata     = (psel & xf.write) ? wdata : '0;
        busy       = (state_q != ST_IDLE);
        rsp_valid  = (state_q == ST_FINISH);
        rsp_err    = rsp_valid & err_q;
        rsp_id     = id_q;
        rsp_result = res_q;
    end

    // State and datapath registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            step_q  <= STEP_WA;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            id_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
            id_q    <= id_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule
